mem_lock_arbiter: RTL

MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

---
 rtl/memarb_pkg.sv | 47 ++++
 rtl/mem_lock_arbiter_if.sv | 51 +++++
 rtl/rr_picker.sv | 40 ++++
 rtl/mem_lock_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// ---------------------------------------------------------------------------
// memarb_pkg
// Shared types and constants for the memory / lock arbiter.
//   C_DEFAULT     : default number of requesting cores (2..8)
//   NLOCK_DEFAULT : default number of lock slots (addressed by a 4-bit index)
//   OWNER_W       : width of a core index (owner field, round-robin pointer)
//   lock_slot_t   : per-slot record {busy, owner}
//   onehot_to_idx : one-hot grant vector -> core index
//   rr_next       : round-robin pointer advance with wrap at n
// ---------------------------------------------------------------------------
package memarb_pkg;

    localparam int C_DEFAULT     = 8;
    localparam int NLOCK_DEFAULT = 16;
    localparam int OWNER_W       = 3;
    localparam int LOCK_ADR_W    = 4;
    localparam int DATA_W        = 16;

    typedef struct packed {
        logic               busy;
        logic [OWNER_W-1:0] owner;
    } lock_slot_t;

    // Grant vectors are one-hot, so OR-ing the indices of set bits is exact.
    function automatic logic [OWNER_W-1:0] onehot_to_idx(input logic [7:0] onehot);
        logic [OWNER_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = idx | OWNER_W'(i);
            end
        end
        return idx;
    endfunction

    // Pointer names the core with highest priority on the next round.
    function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] idx, input int n);
        logic [OWNER_W-1:0] nxt;
        if (int'(idx) == n - 1) begin
            nxt = '0;
        end else begin
            nxt = idx + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_lock_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_lock_arbiter_if
// Bundles the per-core request side and the memory / ack side of the arbiter.
//   master : core side, drives requests, addresses, data, lock operations
//   slave  : arbiter side, drives grant/ack pulses and the memory bus
// Signals:
//   main_mem_read_request / main_mem_write_request [C]   per-core requests
//   main_mem_read_adr / main_mem_write_adr / _dat [C][16] per-core adr/data
//   lock_adr [C][4], lock_en [C], unlock_en [C]           lock operations
//   main_mem_ac [C], lock_ac [C]                          one-hot ack pulses
//   mem_adr, mem_wdat [16], mem_we, mem_re                towards memory
//   lock_err                                              sticky non-owner unlock
// ---------------------------------------------------------------------------
interface mem_lock_arbiter_if
    import memarb_pkg::*;
#(
    parameter int C = C_DEFAULT
);

    logic [C-1:0]                 main_mem_read_request;
    logic [C-1:0]                 main_mem_write_request;
    logic [C-1:0][DATA_W-1:0]     main_mem_read_adr;
    logic [C-1:0][DATA_W-1:0]     main_mem_write_adr;
    logic [C-1:0][DATA_W-1:0]     main_mem_write_dat;
    logic [C-1:0][LOCK_ADR_W-1:0] lock_adr;
    logic [C-1:0]                 lock_en;
    logic [C-1:0]                 unlock_en;

    logic [C-1:0]                 main_mem_ac;
    logic [C-1:0]                 lock_ac;
    logic [DATA_W-1:0]            mem_adr;
    logic [DATA_W-1:0]            mem_wdat;
    logic                         mem_we;
    logic                         mem_re;
    logic                         lock_err;

    modport master (
        output main_mem_read_request, main_mem_write_request,
        output main_mem_read_adr, main_mem_write_adr, main_mem_write_dat,
        output lock_adr, lock_en, unlock_en,
        input  main_mem_ac, lock_ac, mem_adr, mem_wdat, mem_we, mem_re, lock_err
    );

    modport slave (
        input  main_mem_read_request, main_mem_write_request,
        input  main_mem_read_adr, main_mem_write_adr, main_mem_write_dat,
        input  lock_adr, lock_en, unlock_en,
        output main_mem_ac, lock_ac, mem_adr, mem_wdat, mem_we, mem_re, lock_err
    );

endinterface

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector.
//   req   [N]  : request vector
//   ptr   [PW] : index of the highest-priority requester this round
//   grant [N]  : one-hot grant (zero when nothing requests)
//   valid      : any request granted
// ---------------------------------------------------------------------------
module rr_picker
    import memarb_pkg::*;
#(
    parameter int N  = C_DEFAULT,
    parameter int PW = OWNER_W
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Two passes: first the requesters at or above the pointer, then the
    // wrapped-around ones below it.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i]) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_lock_arbiter.sv
// ---------------------------------------------------------------------------
// mem_lock_arbiter
// Round-robin arbiter for C cores sharing one main-memory port, plus an
// independent round-robin lock manager with NLOCK slots.
// Ports:
//   clk      : clock, all state on posedge
//   reset_n  : asynchronous active-low reset
//   bus      : mem_lock_arbiter_if.slave (requests in, grants/memory bus out)
// Build option:
//   MEMARB_LOCK_EN defined   -> full lock manager (busy/owner per slot,
//                               blocked locks wait, lock_err on foreign unlock)
//   MEMARB_LOCK_EN undefined -> every lock/unlock is simply acked round-robin,
//                               no slot state, lock_err tied low
// ---------------------------------------------------------------------------
module mem_lock_arbiter
    import memarb_pkg::*;
#(
    parameter int C     = C_DEFAULT,
    parameter int NLOCK = NLOCK_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_lock_arbiter_if.slave bus
);

    genvar gi;

    if (C < 2 || C > 8 || NLOCK < 1 || NLOCK > 16) begin : g_param_check
        $error("mem_lock_arbiter: C must be 2..8 and NLOCK 1..16");
    end

    // ------------------------------------------------------------------
    // Memory arbitration
    // ------------------------------------------------------------------
    logic [C-1:0]        mem_req;
    logic [C-1:0]        mem_grant;
    logic                mem_valid;
    logic [OWNER_W-1:0]  mem_idx;
    logic                mem_sel_write;
    logic [OWNER_W-1:0]  mem_ptr_reg;
    logic [C-1:0]        main_mem_ac_reg;
    logic [DATA_W-1:0]   mem_adr_reg;
    logic [DATA_W-1:0]   mem_wdat_reg;
    logic                mem_we_reg;
    logic                mem_re_reg;

    assign mem_req = bus.main_mem_read_request | bus.main_mem_write_request;

    rr_picker #(.N(C), .PW(OWNER_W)) u_mem_rr (
        .req   (mem_req),
        .ptr   (mem_ptr_reg),
        .grant (mem_grant),
        .valid (mem_valid)
    );

    assign mem_idx       = onehot_to_idx(8'(mem_grant));
    // A core holding both requests gets its write served first; the read
    // stays asserted and wins a later round.
    assign mem_sel_write = bus.main_mem_write_request[mem_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_ptr_reg     <= '0;
            main_mem_ac_reg <= '0;
            mem_adr_reg     <= '0;
            mem_wdat_reg    <= '0;
            mem_we_reg      <= 1'b0;
            mem_re_reg      <= 1'b0;
        end else begin
            main_mem_ac_reg <= mem_grant;
            mem_we_reg      <= mem_valid && mem_sel_write;
            mem_re_reg      <= mem_valid && !mem_sel_write;
            if (mem_valid) begin
                mem_ptr_reg  <= rr_next(mem_idx, C);
                mem_adr_reg  <= mem_sel_write ? bus.main_mem_write_adr[mem_idx]
                                              : bus.main_mem_read_adr[mem_idx];
                mem_wdat_reg <= bus.main_mem_write_dat[mem_idx];
            end else begin
                mem_adr_reg  <= '0;
                mem_wdat_reg <= '0;
            end
        end
    end

    assign bus.main_mem_ac = main_mem_ac_reg;
    assign bus.mem_adr     = mem_adr_reg;
    assign bus.mem_wdat    = mem_wdat_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_re      = mem_re_reg;

    // ------------------------------------------------------------------
    // Lock arbitration
    // ------------------------------------------------------------------
    logic [C-1:0]        lock_req;
    logic [C-1:0]        lock_grant;
    logic                lock_valid;
    logic [OWNER_W-1:0]  lock_idx;
    logic [OWNER_W-1:0]  lock_ptr_reg;
    logic [C-1:0]        lock_ac_reg;

`ifdef MEMARB_LOCK_EN
    lock_slot_t              slot_reg [NLOCK];
    logic                    lock_err_reg;
    logic [LOCK_ADR_W-1:0]   lock_sel_adr;

    assign lock_sel_adr = bus.lock_adr[lock_idx];
`endif

    // A lock on a busy slot is not offered to the picker, so it waits without
    // blocking other cores. Busy is read from the register, so a slot freed by
    // an unlock becomes lockable only on the following edge.
    for (gi = 0; gi < C; gi++) begin : g_lock_req
`ifdef MEMARB_LOCK_EN
        assign lock_req[gi] = bus.unlock_en[gi]
                            | (bus.lock_en[gi] & ~slot_reg[bus.lock_adr[gi]].busy);
`else
        assign lock_req[gi] = bus.lock_en[gi] | bus.unlock_en[gi];
`endif
    end

    rr_picker #(.N(C), .PW(OWNER_W)) u_lock_rr (
        .req   (lock_req),
        .ptr   (lock_ptr_reg),
        .grant (lock_grant),
        .valid (lock_valid)
    );

    assign lock_idx = onehot_to_idx(8'(lock_grant));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_ptr_reg <= '0;
            lock_ac_reg  <= '0;
`ifdef MEMARB_LOCK_EN
            lock_err_reg <= 1'b0;
            for (int s = 0; s < NLOCK; s++) begin
                slot_reg[s] <= '0;
            end
`endif
        end else begin
            lock_ac_reg <= lock_grant;
            if (lock_valid) begin
                lock_ptr_reg <= rr_next(lock_idx, C);
`ifdef MEMARB_LOCK_EN
                // unlock_en wins when both are raised; unlocking a slot that
                // is free or owned by someone else is acked but flagged.
                if (bus.unlock_en[lock_idx]) begin
                    if (slot_reg[lock_sel_adr].busy &&
                        (slot_reg[lock_sel_adr].owner == lock_idx)) begin
                        slot_reg[lock_sel_adr].busy <= 1'b0;
                    end else begin
                        lock_err_reg <= 1'b1;
                    end
                end else begin
                    slot_reg[lock_sel_adr] <= lock_slot_t'{busy: 1'b1, owner: lock_idx};
                end
`endif
            end
        end
    end

    assign bus.lock_ac = lock_ac_reg;
`ifdef MEMARB_LOCK_EN
    assign bus.lock_err = lock_err_reg;
`else
    assign bus.lock_err = 1'b0;
`endif

endmodule
